// File: rtl/rf_sb.sv
// rtl/rf_sb.sv - multi-port register file with busy-bit scoreboard
module rf_sb #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int AW        = 5,
  parameter int NRD       = 2,
  parameter int NWR       = 2,
  parameter int BYPASS_EN = 1,
  parameter int ZERO_REG  = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NRD*AW-1:0]   i_raddr,
  output logic [NRD*XLEN-1:0] o_rdata,
  output logic [NRD-1:0]      o_rbusy,
  input  logic [NWR-1:0]      i_wen,
  input  logic [NWR*AW-1:0]   i_waddr,
  input  logic [NWR*XLEN-1:0] i_wdata,
  input  logic                i_rsv_en,
  input  logic [AW-1:0]       i_rsv_addr,
  output logic                o_rsv_ok,
  input  logic                i_flush,
  output logic [NREGS-1:0]    o_busy
);

  localparam logic BYP  = (BYPASS_EN != 0);
  localparam logic ZERO = (ZERO_REG != 0);

  logic [XLEN-1:0]  mem    [NREGS];
  logic [XLEN-1:0]  wr_val [NREGS];
  logic [NREGS-1:0] wr_hit;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             rsv_zero;

  // Resolve the write landing on each register; scanning ports upward lets the highest index win
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < NREGS; r++) begin
      wr_val[r] = '0;
      for (int j = 0; j < NWR; j++) begin
        if (i_wen[j] && (i_waddr[j*AW +: AW] == AW'(r))) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = i_wdata[j*XLEN +: XLEN];
        end
      end
    end
    if (ZERO) wr_hit[0] = 1'b0;
  end

  // Commit writes to the flop array
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (wr_hit[r]) mem[r] <= wr_val[r];
      end
    end
  end

  // Combinational read ports with optional same-cycle bypass of data and busy-clear
  always_comb begin
    o_rdata = '0;
    o_rbusy = '0;
    for (int k = 0; k < NRD; k++) begin
      o_rdata[k*XLEN +: XLEN] = mem[i_raddr[k*AW +: AW]];
      o_rbusy[k]              = busy[i_raddr[k*AW +: AW]];
      if (BYP && wr_hit[i_raddr[k*AW +: AW]]) begin
        o_rdata[k*XLEN +: XLEN] = wr_val[i_raddr[k*AW +: AW]];
        o_rbusy[k]              = 1'b0;
      end
      if (ZERO && (i_raddr[k*AW +: AW] == '0)) begin
        o_rdata[k*XLEN +: XLEN] = '0;
        o_rbusy[k]              = 1'b0;
      end
      if (!i_rst_n) begin
        o_rdata[k*XLEN +: XLEN] = '0;
        o_rbusy[k]              = 1'b0;
      end
    end
  end

  // Reservation acceptance; x0 is always free when hardwired, a retiring producer frees the slot under bypass
  always_comb begin
    rsv_zero = ZERO && (i_rsv_addr == '0);
    o_rsv_ok = i_rst_n && i_rsv_en && !i_flush &&
               (rsv_zero || !busy[i_rsv_addr] || (BYP && wr_hit[i_rsv_addr]));
  end

  // Busy next state: flush beats reserve, reserve beats write-clear
  always_comb begin
    busy_nxt = busy;
    for (int r = 0; r < NREGS; r++) begin
      if (wr_hit[r]) busy_nxt[r] = 1'b0;
      if (o_rsv_ok && !rsv_zero && (i_rsv_addr == AW'(r))) busy_nxt[r] = 1'b1;
    end
    if (i_flush) busy_nxt = '0;
    if (ZERO) busy_nxt[0] = 1'b0;
  end

  // Busy-bit state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) busy <= '0;
    else          busy <= busy_nxt;
  end

  // Registered busy vector, forced clear while reset is held
  always_comb begin
    o_busy = i_rst_n ? busy : '0;
  end

endmodule

// File: tb/tb_rf_sb.sv
// tb/tb_rf_sb.sv - scoreboard bench for rf_sb with bypass on and off
module tb_rf_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  raddr = '0;
  logic [1:0]  wen = '0;
  logic [9:0]  waddr = '0;
  logic [63:0] wdata = '0;
  logic        rsv_en = 1'b0;
  logic [4:0]  rsv_addr = '0;
  logic        flush = 1'b0;

  logic [63:0] rdata_a, rdata_b;
  logic [1:0]  rbusy_a, rbusy_b;
  logic        rsv_ok_a, rsv_ok_b;
  logic [31:0] busy_a, busy_b;

  int total = 0;
  int bad = 0;

  typedef struct {
    int          dut;
    int          kind;
    int          port;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];

  always #5 clk = ~clk;

  rf_sb #(.BYPASS_EN(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_raddr(raddr), .o_rdata(rdata_a), .o_rbusy(rbusy_a),
    .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata), .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr),
    .o_rsv_ok(rsv_ok_a), .i_flush(flush), .o_busy(busy_a)
  );

  rf_sb #(.BYPASS_EN(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_raddr(raddr), .o_rdata(rdata_b), .o_rbusy(rbusy_b),
    .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata), .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr),
    .o_rsv_ok(rsv_ok_b), .i_flush(flush), .o_busy(busy_b)
  );

  // kind: 0 rdata, 1 rbusy, 2 rsv_ok, 3 o_busy; dut: 0 bypass, 1 no bypass, 2 both
  task automatic expect_v(input int dut, input int kind, input int port,
                          input logic [31:0] exp, input string name);
    chk_t c;
    c.kind = kind; c.port = port; c.exp = exp; c.name = name;
    if (dut != 1) begin c.dut = 0; q.push_back(c); end
    if (dut != 0) begin c.dut = 1; q.push_back(c); end
  endtask

  function automatic logic [31:0] actual(input chk_t c);
    logic [63:0] rd;
    logic [1:0]  rb;
    rd = (c.dut == 0) ? rdata_a : rdata_b;
    rb = (c.dut == 0) ? rbusy_a : rbusy_b;
    case (c.kind)
      0:       return rd[c.port*32 +: 32];
      1:       return {31'd0, rb[c.port]};
      2:       return {31'd0, (c.dut == 0) ? rsv_ok_a : rsv_ok_b};
      default: return (c.dut == 0) ? busy_a : busy_b;
    endcase
  endfunction

  // Monitor: every check queued for this cycle is compared away from the active edge
  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t c;
      logic [31:0] a;
      c = q.pop_front();
      a = actual(c);
      total++;
      if (a !== c.exp) begin
        bad++;
        $display("FAIL %s dut=%0d got=%h want=%h", c.name, c.dut, a, c.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    wen = '0; rsv_en = 1'b0; flush = 1'b0; raddr = '0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wen[p] = 1'b1;
    waddr[p*5 +: 5] = a;
    wdata[p*32 +: 32] = d;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    raddr[p*5 +: 5] = a;
  endtask

  task automatic rsv(input logic [4:0] a);
    rsv_en = 1'b1;
    rsv_addr = a;
  endtask

  initial begin
    // held in reset: everything zero, reservation ignored
    step();
    rsv(5'd3);
    expect_v(2, 3, 0, 32'h0, "rst_busy");
    expect_v(2, 2, 0, 32'h0, "rst_rsv_ok");
    expect_v(2, 0, 0, 32'h0, "rst_rdata");
    step();
    rst_n = 1'b1;

    step(); wr(0, 5'd5, 32'hDEADBEEF); rd(0, 5'd5);
    expect_v(0, 0, 0, 32'hDEADBEEF, "byp_x5");
    expect_v(1, 0, 0, 32'h0, "nobyp_x5");
    step(); rd(0, 5'd5);
    expect_v(2, 0, 0, 32'hDEADBEEF, "x5_stored");
    step(); rst_n = 1'b0; rd(0, 5'd5);
    expect_v(2, 0, 0, 32'h0, "x5_in_reset");
    expect_v(2, 3, 0, 32'h0, "busy_in_reset");
    step(); rst_n = 1'b1; wr(0, 5'd0, 32'h1234); rd(1, 5'd0);
    expect_v(2, 0, 1, 32'h0, "x0_byp");
    step(); rd(0, 5'd0); rd(1, 5'd5);
    expect_v(2, 0, 0, 32'h0, "x0_stored");
    expect_v(2, 0, 1, 32'h0, "x5_after_reset");

    step(); wr(0, 5'd7, 32'hA5A5A5A5); rd(0, 5'd7);
    expect_v(0, 0, 0, 32'hA5A5A5A5, "byp_x7");
    expect_v(1, 0, 0, 32'h0, "nobyp_x7");
    step(); rd(0, 5'd7);
    expect_v(2, 0, 0, 32'hA5A5A5A5, "x7_stored");

    step(); wr(0, 5'd3, 32'h11); wr(1, 5'd3, 32'h22); rd(0, 5'd3);
    expect_v(0, 0, 0, 32'h22, "prio_byp");
    expect_v(1, 0, 0, 32'h0, "prio_nobyp");
    step(); rd(0, 5'd3); rd(1, 5'd3);
    expect_v(2, 0, 0, 32'h22, "prio_stored");

    step(); rsv(5'd9);
    expect_v(2, 2, 0, 32'h1, "rsv9_ok");
    step(); rsv(5'd9);
    expect_v(2, 3, 0, 32'h200, "busy9_set");
    expect_v(2, 2, 0, 32'h0, "rsv9_again_rej");
    step(); wr(1, 5'd9, 32'h99);
    expect_v(2, 3, 0, 32'h200, "busy9_hold");
    step(); rsv(5'd9);
    expect_v(2, 3, 0, 32'h0, "busy9_cleared");
    expect_v(2, 2, 0, 32'h1, "rsv9_ok2");
    step(); rsv(5'd9); wr(0, 5'd9, 32'h5);
    expect_v(0, 2, 0, 32'h1, "rsv_wr_byp_ok");
    expect_v(1, 2, 0, 32'h0, "rsv_wr_nobyp_rej");
    step();
    expect_v(0, 3, 0, 32'h200, "rsv_wr_stays_busy");
    expect_v(1, 3, 0, 32'h0, "rsv_wr_cleared");

    step(); rsv(5'd4); wr(0, 5'd9, 32'h0);
    expect_v(2, 2, 0, 32'h1, "rsv4_ok");
    step(); rd(0, 5'd4);
    expect_v(2, 1, 0, 32'h1, "rbusy4");
    expect_v(2, 3, 0, 32'h10, "busy4_vec");
    step(); rd(0, 5'd4); wr(1, 5'd4, 32'h44);
    expect_v(0, 1, 0, 32'h0, "rbusy4_byp");
    expect_v(1, 1, 0, 32'h1, "rbusy4_nobyp");
    expect_v(0, 0, 0, 32'h44, "x4_byp");
    step(); rd(0, 5'd4);
    expect_v(2, 3, 0, 32'h0, "busy4_cleared");
    expect_v(2, 0, 0, 32'h44, "x4_stored");

    step(); rsv(5'd1);
    step(); rsv(5'd2);
    step(); rsv(5'd31);
    step(); rsv(5'd6); flush = 1'b1; rd(0, 5'd31);
    expect_v(2, 3, 0, 32'h80000006, "busy_pre_flush");
    expect_v(2, 2, 0, 32'h0, "rsv_flush_rej");
    expect_v(2, 1, 0, 32'h1, "rbusy31");
    step();
    expect_v(2, 3, 0, 32'h0, "busy_post_flush");

    step(); rsv(5'd0); rd(1, 5'd0);
    expect_v(2, 2, 0, 32'h1, "rsv_x0_ok");
    expect_v(2, 1, 1, 32'h0, "rbusy_x0");
    step();
    expect_v(2, 3, 0, 32'h0, "busy_x0_never");

    step();
    step();
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
